// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
// Shared types and constants for the divided-clock health monitor.
//   state_t : monitor FSM states (IDLE, ARM, ACQ, LOCKED, FAULT)
//   ERR_W   : width of the error counter
//   ERR_MAX : saturation value of the error counter
// ---------------------------------------------------------------------------
package clk_div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        ACQ,
        LOCKED,
        FAULT
    } state_t;

    localparam int ERR_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

endpackage

// File: rtl/sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// Two-flop synchronizer followed by a history flop, producing combinational
// rise/fall strobes for a slow asynchronous level. Usable for any slow strobe.
// Ports:
//   clk_in : sampling clock
//   rst_n  : asynchronous active-low reset, clears all three flops
//   d      : asynchronous input level
//   rise   : high for one cycle after the synchronized level goes 0->1
//   fall   : high for one cycle after the synchronized level goes 1->0
// ---------------------------------------------------------------------------
module sync_edge (
    input  logic clk_in,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // NOTE: non-blocking assignments let every flop capture its pre-edge
    // input; blocking ones here would collapse the chain into a single stage.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/clk_div_monitor.sv
// ---------------------------------------------------------------------------
// clk_div_monitor
// Health monitor for an even clock divider. Synchronizes clk_div into the
// clk_in domain, emits registered rise/fall ticks, measures each high and low
// half-period and tracks lock/fault against the expected half-period N.
// Ports:
//   clk_in    : the only clock
//   rst_n     : asynchronous active-low reset
//   en        : monitor enable; low forces IDLE
//   clr_err   : one-cycle pulse, clears err_cnt and leaves FAULT
//   clk_div   : divided clock under test
//   rise_tick : one-cycle pulse per synchronized rising edge
//   fall_tick : one-cycle pulse per synchronized falling edge
//   locked    : state is LOCKED
//   fault     : state is FAULT
//   last_hi   : last measured high half-period
//   last_lo   : last measured low half-period
//   err_cnt   : bad half-periods plus timeouts while locked/faulted, saturating
// ---------------------------------------------------------------------------
module clk_div_monitor
    import clk_div_pkg::*;
#(
    parameter int N        = 2,
    parameter int WIDTH    = 7,
    parameter int TOL      = 0,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 4 * N
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr_err,
    input  logic             clk_div,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic             locked,
    output logic             fault,
    output logic [WIDTH-1:0] last_hi,
    output logic [WIDTH-1:0] last_lo,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int GOOD_W  = $clog2(LOCK_CNT + 1);
    localparam int H_MIN_I = (N > TOL) ? (N - TOL) : 0;

    localparam logic [WIDTH-1:0]  H_MIN     = WIDTH'(H_MIN_I);
    localparam logic [WIDTH-1:0]  H_MAX     = WIDTH'(N + TOL);
    localparam logic [WIDTH-1:0]  HP_LAST   = WIDTH'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0]  HP_MAX    = '1;
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);

    state_t             state;
    logic [WIDTH-1:0]   hp;
    logic [GOOD_W-1:0]  good;

    logic               div_rise;
    logic               div_fall;
    logic               edge_seen;
    logic [WIDTH-1:0]   h;
    logic               edge_good;
    logic               active;
    logic               timeout;
    logic               error_hit;
    logic               error_evt;
    logic               measuring;
    logic [ERR_W-1:0]   err_base;

    sync_edge u_sync (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .d      (clk_div),
        .rise   (div_rise),
        .fall   (div_fall)
    );

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        edge_seen = div_rise | div_fall;
        h         = hp + WIDTH'(1);
        edge_good = (h >= H_MIN) && (h <= H_MAX);
        active    = en && (state != IDLE);
        // A stall is only declared when this cycle carries no edge.
        timeout   = active && !edge_seen && (hp == HP_LAST);
        error_hit = (edge_seen && !edge_good) || timeout;
        error_evt = en && ((state == LOCKED) || (state == FAULT)) && error_hit;
        // The edge that leaves ARM closes a partial half-period; discard it.
        measuring = en && ((state == ACQ) || (state == LOCKED) || (state == FAULT));
        // Clear is applied before a same-cycle error is counted.
        err_base  = clr_err ? '0 : err_cnt;
    end

    // Ticks are registered so they line up with the state/measurement update.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            rise_tick <= div_rise;
            fall_tick <= div_fall;
        end
    end

    // Half-period counter: restarts on every edge and on every timeout.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hp <= '0;
        end else if (!active) begin
            hp <= '0;
        end else if (edge_seen || timeout) begin
            hp <= '0;
        end else if (hp != HP_MAX) begin
            hp <= hp + WIDTH'(1);
        end
    end

    // A falling edge closes a high phase, a rising edge closes a low phase.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            last_hi <= '0;
            last_lo <= '0;
        end else if (measuring) begin
            if (div_fall) last_hi <= h;
            if (div_rise) last_lo <= h;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (error_evt && (err_base != ERR_MAX)) begin
            err_cnt <= err_base + ERR_W'(1);
        end else begin
            err_cnt <= err_base;
        end
    end

    // Monitor FSM; locked/fault are registered alongside the state.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            good   <= '0;
            locked <= 1'b0;
            fault  <= 1'b0;
        end else if (!en) begin
            state  <= IDLE;
            good   <= '0;
            locked <= 1'b0;
            fault  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= ARM;
                end
                ARM: begin
                    if (edge_seen) state <= ACQ;
                end
                ACQ: begin
                    if (timeout) begin
                        state <= ARM;
                        good  <= '0;
                    end else if (edge_seen) begin
                        if (!edge_good) begin
                            good <= '0;
                        end else if (good == GOOD_LAST) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                            good   <= '0;
                        end else begin
                            good <= good + GOOD_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (error_hit) begin
                        state  <= FAULT;
                        locked <= 1'b0;
                        fault  <= 1'b1;
                    end
                end
                FAULT: begin
                    if (clr_err && !error_hit) begin
                        state <= ARM;
                        fault <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    good   <= '0;
                    locked <= 1'b0;
                    fault  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// ---------------------------------------------------------------------------
// tb_clk_div_monitor
// Scoreboard bench for clk_div_monitor with N=2, TOL=0, LOCK_CNT=4,
// TIMEOUT=8. Each clk_div toggle pushes the hand-computed tick response; a
// monitor pops and compares whenever the DUT raises a tick.
// ---------------------------------------------------------------------------
module tb_clk_div_monitor;

    logic       clk_in  = 1'b0;
    logic       rst_n   = 1'b0;
    logic       en      = 1'b0;
    logic       clr_err = 1'b0;
    logic       clk_div = 1'b0;
    logic       rise_tick;
    logic       fall_tick;
    logic       locked;
    logic       fault;
    logic [6:0] last_hi;
    logic [6:0] last_lo;
    logic [7:0] err_cnt;

    typedef struct packed {
        logic       rise;
        logic       fall;
        logic       lck;
        logic       flt;
        logic [6:0] hi;
        logic [6:0] lo;
        logic [7:0] err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_exp;
    exp_t mon_act;
    int   checks   = 0;
    int   failures = 0;
    int   tick_no  = 0;
    bit   found;

    clk_div_monitor #(
        .N        (2),
        .WIDTH    (7),
        .TOL      (0),
        .LOCK_CNT (4),
        .TIMEOUT  (8)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .en        (en),
        .clr_err   (clr_err),
        .clk_div   (clk_div),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .locked    (locked),
        .fault     (fault),
        .last_hi   (last_hi),
        .last_lo   (last_lo),
        .err_cnt   (err_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Toggle clk_div after `half` rising clk_in edges (source-synchronous).
    task automatic toggle(input int half);
        repeat (half) @(posedge clk_in);
        #1 clk_div = ~clk_div;
    endtask

    // Queue the expected tick response, then issue the toggle.
    task automatic step(input int half, input logic lck, input logic flt,
                        input logic [6:0] hi, input logic [6:0] lo, input logic [7:0] err);
        exp_t e;
        e.rise = ~clk_div;
        e.fall = clk_div;
        e.lck  = lck;
        e.flt  = flt;
        e.hi   = hi;
        e.lo   = lo;
        e.err  = err;
        exp_q.push_back(e);
        toggle(half);
    endtask

    task automatic apply_reset();
        @(posedge clk_in);
        #1 rst_n = 1'b0;
        clr_err = 1'b0;
        clk_div = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: compare every tick against the head of the scoreboard.
    always @(negedge clk_in) begin
        if (rst_n && (rise_tick || fall_tick)) begin
            tick_no++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tick%0d: got unexpected tick rise=%b fall=%b, expected none",
                         tick_no, rise_tick, fall_tick);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_act = {rise_tick, fall_tick, locked, fault, last_hi, last_lo, err_cnt};
                check($sformatf("tick%0d", tick_no), 32'(mon_act), 32'(mon_exp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_rise_tick", 32'(rise_tick), 0);
        check("rst_fall_tick", 32'(fall_tick), 0);
        check("rst_locked",    32'(locked),    0);
        check("rst_fault",     32'(fault),     0);
        check("rst_last_hi",   32'(last_hi),   0);
        check("rst_last_lo",   32'(last_lo),   0);
        check("rst_err_cnt",   32'(err_cnt),   0);
        rst_n = 1'b1;
        en    = 1'b1;

        // Wrong ratio: toggling every 3 cycles never locks or faults
        step(3, 0, 0, 0, 0, 0);
        step(3, 0, 0, 3, 0, 0);
        for (int i = 0; i < 6; i++) step(3, 0, 0, 3, 3, 0);
        repeat (4) @(posedge clk_in);
        #1;
        check("ratio_drain",  32'(exp_q.size()), 0);
        check("ratio_locked", 32'(locked), 0);
        check("ratio_fault",  32'(fault),  0);
        check("ratio_err",    32'(err_cnt), 0);

        // Lock on the real divider output
        apply_reset();
        step(2, 0, 0, 0, 0, 0);
        step(2, 0, 0, 2, 0, 0);
        step(2, 0, 0, 2, 2, 0);
        step(2, 0, 0, 2, 2, 0);
        step(2, 1, 0, 2, 2, 0);
        for (int i = 0; i < 4; i++) step(2, 1, 0, 2, 2, 0);

        // Stall high after lock
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            if (rise_tick) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL stall_tick: got no rise tick within 10 cycles, expected one");
        end
        repeat (7) @(negedge clk_in);
        check("stall7_fault",  32'(fault),  0);
        check("stall7_locked", 32'(locked), 1);
        @(negedge clk_in);
        check("stall8_fault",  32'(fault),   1);
        check("stall8_locked", 32'(locked),  0);
        check("stall8_err",    32'(err_cnt), 1);
        repeat (7) @(negedge clk_in);
        check("stall15_err", 32'(err_cnt), 1);
        @(negedge clk_in);
        check("stall16_err", 32'(err_cnt), 2);

        // Clear and recover
        clr_err = 1'b1;
        @(posedge clk_in);
        #1 clr_err = 1'b0;
        check("clr_fault",  32'(fault),   0);
        check("clr_locked", 32'(locked),  0);
        check("clr_err",    32'(err_cnt), 0);
        for (int i = 0; i < 4; i++) step(2, 0, 0, 2, 2, 0);
        step(2, 1, 0, 2, 2, 0);

        // Bad edge while locked, then clear together with another bad edge
        step(3, 0, 1, 2, 3, 1);
        exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b1, 7'd3, 7'd3, 8'd1});
        toggle(3);
        repeat (2) @(posedge clk_in);
        #1 clr_err = 1'b1;
        @(posedge clk_in);
        #1 clr_err = 1'b0;
        check("simul_err",   32'(err_cnt), 1);
        check("simul_fault", 32'(fault),   1);

        // Disable retains err_cnt and measurements
        @(posedge clk_in);
        #1 en = 1'b0;
        @(posedge clk_in);
        #1;
        check("dis_fault",   32'(fault),   0);
        check("dis_err",     32'(err_cnt), 1);
        check("dis_last_hi", 32'(last_hi), 3);
        check("dis_last_lo", 32'(last_lo), 3);
        en = 1'b1;

        // Relock with a nonzero err_cnt, then reset asynchronously
        step(2, 0, 0, 3, 3, 1);
        step(2, 0, 0, 2, 3, 1);
        step(2, 0, 0, 2, 2, 1);
        step(2, 0, 0, 2, 2, 1);
        step(2, 1, 0, 2, 2, 1);
        toggle(2);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_in);
            #2;
            if (fall_tick) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL arst_tick: got no fall tick within 10 cycles, expected one");
        end
        check("arst_pre_locked", 32'(locked), 1);
        rst_n = 1'b0;
        #1;
        check("arst_fall_tick", 32'(fall_tick), 0);
        check("arst_rise_tick", 32'(rise_tick), 0);
        check("arst_locked",    32'(locked),    0);
        check("arst_fault",     32'(fault),     0);
        check("arst_last_hi",   32'(last_hi),   0);
        check("arst_last_lo",   32'(last_lo),   0);
        check("arst_err_cnt",   32'(err_cnt),   0);
        check("final_drain",    32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
